// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants for the MIPS front end.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Word-aligned and inside [base, base+span); widened to 33 bits so base+span cannot overflow.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] span);
    logic [ADDR_W:0] a, lo, hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, span};
    return (addr[1:0] == 2'b00) && (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Generic DEPTH-entry synchronous FIFO with flush; head data reads as zero when empty.
module ifu_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & ((count_q != FULL_CNT) | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch stage: PC register, imem addressing and a {pc, instr} queue towards decode.
// Optional fetch-address checking is built when IFU_ADDR_CHECK_EN is defined.
module ifu_fetch_queue
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] IM_BYTES = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] npc_in,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] pc_q,
  output logic        addr_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      pc_d;
  logic [CNT_W-1:0] count;
  logic             empty, pop, space, push;
  fetch_entry_t     wr_entry, head;

  assign imem_addr = pc_q;
  assign id_valid  = ~empty;
  assign pop       = id_valid & id_ready;
  assign space     = (count < FULL_CNT) | pop;

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = imem_rdata;
  assign id_pc          = head.pc;
  assign id_instr       = head.instr;

`ifdef IFU_ADDR_CHECK_EN
  logic addr_err_q, addr_err_d, attempt;

  assign attempt  = ~redirect & ~addr_err_q & space;
  assign push     = attempt & addr_legal(pc_q, RESET_PC, IM_BYTES);
  assign addr_err = addr_err_q;

  // A redirect only clears the error when it lands somewhere legal.
  always_comb begin
    addr_err_d = addr_err_q;
    if (redirect) begin
      if (addr_legal(npc_in, RESET_PC, IM_BYTES)) addr_err_d = 1'b0;
    end else if (attempt && !push) begin
      addr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) addr_err_q <= 1'b0;
    else       addr_err_q <= addr_err_d;
  end
`else
  assign push     = ~redirect & space;
  assign addr_err = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = npc_in;
    else if (push) pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  ifu_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue with an inverting-address ROM model.
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] npc_in;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] pc_q;
  logic        addr_err;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hFFFF_FFFF;

  ifu_fetch_queue dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .npc_in     (npc_in),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .pc_q       (pc_q),
    .addr_err   (addr_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    redirect = 1'b0;
    npc_in   = '0;
    id_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_pc", pc_q, 32'h3000);
    check_eq("rst_valid", {31'b0, id_valid}, 32'd0);
    check_eq("rst_id_pc", id_pc, 32'd0);
    check_eq("rst_id_instr", id_instr, 32'd0);
    check_eq("rst_err", {31'b0, addr_err}, 32'd0);
    check_eq("rst_imem_addr", imem_addr, 32'h3000);

    // Streaming with decode always ready: one-cycle latency, no bypass.
    reset = 1'b0;
    check_eq("empty_valid", {31'b0, id_valid}, 32'd0);
    tick();
    check_eq("s1_valid", {31'b0, id_valid}, 32'd1);
    check_eq("s1_pc", id_pc, 32'h3000);
    check_eq("s1_instr", id_instr, 32'hFFFF_CFFF);
    tick();
    check_eq("s2_pc", id_pc, 32'h3004);
    tick();
    check_eq("s3_pc", id_pc, 32'h3008);
    check_eq("s3_pcq", pc_q, 32'h300C);

    // Decode stall from reset: queue fills with 3000/3004 and the PC stalls.
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("stall_valid", {31'b0, id_valid}, 32'd1);
    check_eq("stall_head", id_pc, 32'h3000);
    check_eq("stall_pcq", pc_q, 32'h3008);
    id_ready = 1'b1;
    tick();
    check_eq("drain0", id_pc, 32'h3004);
    tick();
    check_eq("drain1", id_pc, 32'h3008);
    tick();
    check_eq("drain2", id_pc, 32'h300C);
    check_eq("drain2_instr", id_instr, 32'hFFFF_CFF3);
    check_eq("drain_pcq", pc_q, 32'h3014);

    // Redirect on a full queue with a simultaneous pop.
    redirect = 1'b1;
    npc_in   = 32'h3100;
    tick();
    redirect = 1'b0;
    check_eq("redir_valid", {31'b0, id_valid}, 32'd0);
    check_eq("redir_pcq", pc_q, 32'h3100);
    check_eq("redir_id_pc", id_pc, 32'd0);
    tick();
    check_eq("redir_head_valid", {31'b0, id_valid}, 32'd1);
    check_eq("redir_head_pc", id_pc, 32'h3100);
    check_eq("redir_head_instr", id_instr, 32'hFFFF_CEFF);

`ifndef IFU_ADDR_CHECK_EN
    // PC wraps silently past the top of the address space.
    redirect = 1'b1;
    npc_in   = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    tick();
    check_eq("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_addr2", imem_addr, 32'h0000_0000);
    check_eq("wrap_head", id_pc, 32'hFFFF_FFFC);
    check_eq("wrap_err", {31'b0, addr_err}, 32'd0);
`else
    // Misaligned target halts fetch; a legal redirect recovers.
    redirect = 1'b1;
    npc_in   = 32'h3002;
    tick();
    redirect = 1'b0;
    check_eq("bad_err_pending", {31'b0, addr_err}, 32'd0);
    tick();
    check_eq("bad_err", {31'b0, addr_err}, 32'd1);
    check_eq("bad_pcq", pc_q, 32'h3002);
    tick();
    check_eq("bad_nopush", {31'b0, id_valid}, 32'd0);
    check_eq("bad_hold", pc_q, 32'h3002);
    redirect = 1'b1;
    npc_in   = 32'h3010;
    tick();
    redirect = 1'b0;
    check_eq("fix_err", {31'b0, addr_err}, 32'd0);
    check_eq("fix_pcq", pc_q, 32'h3010);
    tick();
    check_eq("fix_head", id_pc, 32'h3010);
`endif

    // Asynchronous reset mid-cycle with a full queue.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("pre_rst_valid", {31'b0, id_valid}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check_eq("arst_valid", {31'b0, id_valid}, 32'd0);
    check_eq("arst_err", {31'b0, addr_err}, 32'd0);
    check_eq("arst_pcq", pc_q, 32'h3000);
    tick();
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
